// File: rtl/vpi_mem_selfcheck.sv
// Publicly accessible memory array with a host write port and a sequential walker
// that either fills every entry with the expected pattern or checks every entry against it.
module vpi_mem_selfcheck #(
   parameter int               WIDTH       = 32,
   parameter int               LO          = 1,
   parameter int               HI          = 16,
   parameter int               ADDR_W      = 5,
   parameter logic [WIDTH-1:0] PATTERN_XOR = '0,
   parameter int               CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data,
   input  logic              start,
   input  logic              mode,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [WIDTH-1:0]  first_err_data
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [ADDR_W-1:0] A_LO = ADDR_W'(LO);
   localparam logic [ADDR_W-1:0] A_HI = ADDR_W'(HI);

   // Storage spans the full address space so any index width lints cleanly;
   // only LO..HI is ever written or read back.
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [1:0]        state;
   logic [ADDR_W-1:0] ptr;
   logic              mode_r;
   logic              run_cyc;
   logic              fill_we;
   logic              mis;
   logic [WIDTH-1:0]  cur;
   logic [CNT_W-1:0]  err_nxt;

   function automatic logic [WIDTH-1:0] expected(input logic [ADDR_W-1:0] i);
      logic [WIDTH+ADDR_W-1:0] ext;
      ext = {{WIDTH{1'b0}}, i};
      return ext[WIDTH-1:0] ^ PATTERN_XOR;
   endfunction

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return (a >= A_LO) && (a <= A_HI);
   endfunction

   assign run_cyc = (state == S_RUN);
   assign fill_we = run_cyc && mode_r;
   assign cur     = mem[ptr];
   // Case-inequality so an uninitialised entry is reported as a mismatch in simulation.
   assign mis     = run_cyc && !mode_r && (cur !== expected(ptr));
   assign err_nxt = (mis && (err_count != '1)) ? err_count + CNT_W'(1) : err_count;

   // The fill write is issued last so it wins over a host write to the same entry.
   always_ff @(posedge clk) begin
      if (wr_en && in_range(wr_addr))
         mem[wr_addr] <= wr_data;
      if (fill_we)
         mem[ptr] <= expected(ptr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rd_data <= '0;
      else
         rd_data <= in_range(rd_addr) ? mem[rd_addr] : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         ptr            <= '0;
         mode_r         <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
         first_err_data <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_r         <= mode;
                  ptr            <= A_HI;
                  err_count      <= '0;
                  pass           <= 1'b0;
                  first_err_addr <= '0;
                  first_err_data <= '0;
                  busy           <= 1'b1;
                  state          <= S_RUN;
               end
            end
            S_RUN: begin
               err_count <= err_nxt;
               if (mis && (err_count == '0)) begin
                  first_err_addr <= ptr;
                  first_err_data <= cur;
               end
               if (ptr == A_LO) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= !mode_r && (err_nxt == '0);
               end else begin
                  ptr <= ptr - 1'b1;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vpi_mem_selfcheck.sv
// Scoreboard bench: two instances (default and CNT_W=2/PATTERN_XOR) share stimulus;
// sel picks which one is observed. A reference memory model per instance predicts results.
module tb_vpi_mem_selfcheck;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [4:0]  rd_addr = '0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic        sel = 1'b0;

   logic [31:0] rd1, rd2, fd1, fd2;
   logic        busy1, busy2, done1, done2, pass1, pass2;
   logic [7:0]  err1;
   logic [1:0]  err2;
   logic [4:0]  fa1, fa2;

   logic [31:0] o_rd, o_fd;
   logic        o_busy, o_done, o_pass;
   logic [7:0]  o_err;
   logic [4:0]  o_fa;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q [$];
   logic [31:0] m1 [32];
   logic [31:0] m2 [32];

   localparam logic [31:0] XOR2 = 32'hFFFF0000;

   vpi_mem_selfcheck u_dut1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd1), .start(start), .mode(mode), .busy(busy1),
      .done(done1), .pass(pass1), .err_count(err1), .first_err_addr(fa1),
      .first_err_data(fd1));

   vpi_mem_selfcheck #(.CNT_W(2), .PATTERN_XOR(XOR2)) u_dut2 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd2), .start(start), .mode(mode), .busy(busy2),
      .done(done2), .pass(pass2), .err_count(err2), .first_err_addr(fa2),
      .first_err_data(fd2));

   assign o_rd   = sel ? rd2   : rd1;
   assign o_fd   = sel ? fd2   : fd1;
   assign o_busy = sel ? busy2 : busy1;
   assign o_done = sel ? done2 : done1;
   assign o_pass = sel ? pass2 : pass1;
   assign o_err  = sel ? {6'd0, err2} : err1;
   assign o_fa   = sel ? fa2   : fa1;

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic pop_chk(input string tag, input logic [31:0] got);
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s scoreboard empty got=%h", tag, got);
      end else begin
         chk(tag, got, exp_q.pop_front());
      end
   endtask

   function automatic logic [31:0] pat(input int i, input logic s);
      return 32'(i) ^ (s ? XOR2 : 32'h0);
   endfunction

   function automatic logic [31:0] mval(input int i);
      return sel ? m2[i] : m1[i];
   endfunction

   task automatic wr(input int a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
      if (a >= 1 && a <= 16) begin
         m1[a] = d;
         m2[a] = d;
      end
   endtask

   task automatic rd(input int a);
      rd_addr = 5'(a);
      exp_q.push_back((a >= 1 && a <= 16) ? mval(a) : 32'h0);
      @(negedge clk);
      pop_chk("rd", o_rd);
   endtask

   // Walk with optional extra start pulse during RUN cycle pulse_at.
   task automatic walk(input logic m, input int pulse_at);
      int cnt, fa, ndone, dcyc, nbusy, cmax;
      logic [31:0] fd;
      cnt = 0; fa = 0; fd = 0; ndone = 0; dcyc = 0; nbusy = 0;
      cmax = sel ? 3 : 255;
      if (!m) begin
         for (int i = 16; i >= 1; i--) begin
            if (mval(i) !== pat(i, sel)) begin
               if (cnt == 0) begin
                  fa = i;
                  fd = mval(i);
               end
               if (cnt < cmax) cnt++;
            end
         end
      end else begin
         for (int i = 1; i <= 16; i++) begin
            m1[i] = pat(i, 1'b0);
            m2[i] = pat(i, 1'b1);
         end
      end
      exp_q.push_back(32'd17);
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd16);
      exp_q.push_back(32'(!m && cnt == 0));
      exp_q.push_back(32'(cnt));
      exp_q.push_back(32'(fa));
      exp_q.push_back(fd);
      mode = m; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         if (o_done) begin
            ndone++;
            if (dcyc == 0) dcyc = c;
         end
         if (o_busy) nbusy++;
         start = (c == pulse_at);
         @(negedge clk);
      end
      start = 1'b0;
      pop_chk("done_cycle", 32'(dcyc));
      pop_chk("done_count", 32'(ndone));
      pop_chk("busy_cycles", 32'(nbusy));
      pop_chk("pass", 32'(o_pass));
      pop_chk("err_count", 32'(o_err));
      pop_chk("first_err_addr", 32'(o_fa));
      pop_chk("first_err_data", o_fd);
   endtask

   initial begin
      int ndone;
      @(negedge clk);
      chk("rst_rd", o_rd, 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_pass", 32'(o_pass), 0);
      chk("rst_err", 32'(o_err), 0);
      chk("rst_fa", 32'(o_fa), 0);
      chk("rst_fd", o_fd, 0);
      rst = 1'b0;
      @(negedge clk);

      // fill, then clean check, then read back every entry
      walk(1'b1, 0);
      walk(1'b0, 0);
      for (int i = 1; i <= 16; i++) rd(i);

      // two corrupted entries; stray start mid-walk must be ignored
      wr(3, 32'd99);
      wr(7, 32'd0);
      walk(1'b0, 5);
      chk("mis_err_const", 32'(o_err), 2);
      chk("mis_fa_const", 32'(o_fa), 7);

      // out-of-range writes are dropped, reads return 0
      walk(1'b1, 0);
      wr(0, 32'hDEAD);
      wr(17, 32'hDEAD);
      walk(1'b0, 0);
      rd(0);
      rd(17);

      // read-before-write on the same index
      rd_addr = 5'd5;
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55;
      exp_q.push_back(m1[5]);
      @(negedge clk);
      wr_en = 1'b0;
      pop_chk("rbw_old", o_rd);
      m1[5] = 32'h55;
      m2[5] = 32'h55;
      rd(5);
      wr(5, 32'd5);

      // reset in the middle of a fill over a corrupted array
      for (int i = 1; i <= 16; i++) wr(i, 32'hBAD0);
      mode = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(o_busy), 0);
      chk("midrst_done", 32'(o_done), 0);
      for (int i = 9; i <= 16; i++) begin
         m1[i] = pat(i, 1'b0);
         m2[i] = pat(i, 1'b1);
      end
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         if (o_done || o_busy) ndone++;
         @(negedge clk);
      end
      chk("midrst_quiet", 32'(ndone), 0);
      walk(1'b0, 0);
      chk("midrst_err_const", 32'(o_err), 8);
      chk("midrst_fa_const", 32'(o_fa), 8);

      // second instance: saturating counter and xor pattern
      sel = 1'b1;
      for (int i = 1; i <= 16; i++) wr(i, 32'(i));
      walk(1'b0, 0);
      chk("sat_err_const", 32'(o_err), 3);
      walk(1'b1, 0);
      walk(1'b0, 0);
      rd(5);
      chk("xor_rd_const", o_rd, 32'hFFFF0005);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
